// File: rtl/i2c_reg_bank_pkg.sv
// Shared definitions for the I2C register bank: byte width, idle transmit byte, FSM states.
// Used by i2c_reg_bank and i2c_reg_array.
package i2c_reg_bank_pkg;

  localparam int         BYTE_W       = 8;
  localparam logic [7:0] IDLE_TX_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PTR   = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_DROP  = 3'd4
  } state_t;

endpackage

// File: rtl/i2c_reg_array.sv
// NREG x 8 register storage: one write port, combinational read mux, flattened view.
// Writes land at the clock edge; read data reflects the current register contents.
module i2c_reg_array
  import i2c_reg_bank_pkg::*;
#(
  parameter int         NREG      = 16,
  parameter int         PTR_W     = $clog2(NREG),
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_addr,
  input  logic [BYTE_W-1:0]  wr_data,
  input  logic [PTR_W-1:0]   rd_addr,
  output logic [BYTE_W-1:0]  rd_data,
  output logic [NREG*8-1:0]  reg_flat
);

  logic [BYTE_W-1:0] regs_q [NREG];
  logic [BYTE_W-1:0] regs_d [NREG];

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (wr_addr == PTR_W'(i))) begin
        regs_d[i] = wr_data;
      end
    end
  end

  // Address compare rather than direct indexing keeps non-power-of-2 NREG safe.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_addr == PTR_W'(i)) begin
        rd_data = regs_q[i];
      end
    end
  end

  always_comb begin
    reg_flat = '0;
    for (int i = 0; i < NREG; i++) begin
      reg_flat[8*i +: 8] = regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/i2c_reg_bank.sv
// I2C register bank: pointer+data write protocol, auto-increment reads, ACK/NACK decisions.
// Responses one cycle after rx_valid/tx_req, no backpressure; I2C_REG_BANK_WPROT_EN enables LOCK.
module i2c_reg_bank
  import i2c_reg_bank_pkg::*;
#(
  parameter int         NREG      = 16,
  parameter int         PTR_W     = $clog2(NREG),
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               txn_start,
  input  logic               txn_rw,
  input  logic               txn_stop,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ack,
  output logic               ack_valid,
  input  logic               tx_req,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  output logic [NREG*8-1:0]  reg_q,
  output logic               wr_strobe,
  output logic [PTR_W-1:0]   wr_addr
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREG - 1);

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              rx_ack_q, rx_ack_d;
  logic              ack_valid_q, ack_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0]  wr_addr_q, wr_addr_d;

  logic              wr_en;
  logic [7:0]        rd_data;
  logic [PTR_W-1:0]  ptr_inc;
  logic              ptr_in_range;
  logic              write_ok;

  i2c_reg_array #(
    .NREG      (NREG),
    .PTR_W     (PTR_W),
    .RESET_VAL (RESET_VAL)
  ) u_reg_array (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (ptr_q),
    .wr_data  (rx_data),
    .rd_addr  (ptr_q),
    .rd_data  (rd_data),
    .reg_flat (reg_q)
  );

  assign ptr_inc      = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
  assign ptr_in_range = ({1'b0, rx_data} < 9'(NREG));

`ifdef I2C_REG_BANK_WPROT_EN
  // The last register is LOCK; it stays writable so the lock can always be released.
  assign write_ok = (ptr_q == LAST_IDX) || !reg_q[8*(NREG-1)];
`else
  assign write_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rx_ack_d    = rx_ack_q;
    ack_valid_d = 1'b0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_en       = 1'b0;

    if (tx_req) begin
      tx_valid_d = 1'b1;
      if (state_q == ST_READ) begin
        tx_data_d = rd_data;
        ptr_d     = ptr_inc;
      end else begin
        tx_data_d = IDLE_TX_BYTE;
      end
    end

    // A byte arriving with a new address phase belongs to nothing and is dropped silently.
    if (rx_valid && !txn_start) begin
      ack_valid_d = 1'b1;
      rx_ack_d    = 1'b0;
      case (state_q)
        ST_PTR: begin
          if (ptr_in_range) begin
            ptr_d    = rx_data[PTR_W-1:0];
            rx_ack_d = 1'b1;
            state_d  = ST_WRITE;
          end else begin
            state_d  = ST_DROP;
          end
        end
        ST_WRITE: begin
          ptr_d = ptr_inc;
          if (write_ok) begin
            wr_en       = 1'b1;
            rx_ack_d    = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = ptr_q;
          end
        end
        default: ;
      endcase
    end

    if (txn_start) begin
      state_d = txn_rw ? ST_READ : ST_PTR;
    end
    if (txn_stop) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rx_ack_q    <= 1'b0;
      ack_valid_q <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rx_ack_q    <= rx_ack_d;
      ack_valid_q <= ack_valid_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign rx_ack    = rx_ack_q;
  assign ack_valid = ack_valid_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Bench for i2c_reg_bank: directed transactions plus random bus events against a transaction-level model.
// Honours I2C_REG_BANK_WPROT_EN the same way as the design.
module tb_i2c_reg_bank;

  localparam int NREG  = 16;
  localparam int PTR_W = 4;
  localparam int W     = NREG * 8;

  localparam int M_IDLE  = 0;
  localparam int M_PTR   = 1;
  localparam int M_WRITE = 2;
  localparam int M_READ  = 3;
  localparam int M_DROP  = 4;

  logic              clk;
  logic              reset;
  logic              txn_start;
  logic              txn_rw;
  logic              txn_stop;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ack;
  logic              ack_valid;
  logic              tx_req;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic [W-1:0]      reg_q;
  logic              wr_strobe;
  logic [PTR_W-1:0]  wr_addr;

  i2c_reg_bank #(.NREG(NREG), .PTR_W(PTR_W), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .txn_start (txn_start),
    .txn_rw    (txn_rw),
    .txn_stop  (txn_stop),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ack    (rx_ack),
    .ack_valid (ack_valid),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .reg_q     (reg_q),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: register contents, pointer and what the current transaction expects next.
  logic [7:0] m_regs [NREG];
  int         m_ptr;
  int         m_mode;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] model_flat();
    logic [W-1:0] f;
    f = '0;
    for (int i = 0; i < NREG; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  function automatic bit may_write(input int idx);
`ifdef I2C_REG_BANK_WPROT_EN
    return (idx == NREG - 1) || (m_regs[NREG-1][0] == 1'b0);
`else
    return (idx >= 0);
`endif
  endfunction

  task automatic step(input logic st, input logic rw, input logic sp, input logic rv,
                      input logic [7:0] rd, input logic tr, input logic rs);
    logic       e_ackv, e_ack, e_txv, e_wr;
    logic [7:0] e_txd;
    int         e_wa;
    e_ackv = 0; e_ack = 0; e_txv = 0; e_txd = 8'h00; e_wr = 0; e_wa = 0;
    if (rs) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
      m_ptr  = 0;
      m_mode = M_IDLE;
    end else begin
      if (tr) begin
        e_txv = 1;
        if (m_mode == M_READ) begin
          e_txd = m_regs[m_ptr];
          m_ptr = (m_ptr + 1) % NREG;
        end else begin
          e_txd = 8'hFF;
        end
      end
      if (rv && !st) begin
        e_ackv = 1;
        if (m_mode == M_PTR) begin
          if (int'(rd) < NREG) begin
            m_ptr  = int'(rd);
            e_ack  = 1;
            m_mode = M_WRITE;
          end else begin
            m_mode = M_DROP;
          end
        end else if (m_mode == M_WRITE) begin
          if (may_write(m_ptr)) begin
            m_regs[m_ptr] = rd;
            e_wr  = 1;
            e_wa  = m_ptr;
            e_ack = 1;
          end
          m_ptr = (m_ptr + 1) % NREG;
        end
      end
      if (st) m_mode = rw ? M_READ : M_PTR;
      if (sp) m_mode = M_IDLE;
    end

    reset = rs; txn_start = st; txn_rw = rw; txn_stop = sp;
    rx_valid = rv; rx_data = rd; tx_req = tr;
    @(posedge clk);
    #1;
    check("ack_valid", W'(ack_valid), W'(e_ackv));
    if (e_ackv) check("rx_ack", W'(rx_ack), W'(e_ack));
    check("tx_valid", W'(tx_valid), W'(e_txv));
    if (e_txv) check("tx_data", W'(tx_data), W'(e_txd));
    check("wr_strobe", W'(wr_strobe), W'(e_wr));
    if (e_wr) check("wr_addr", W'(wr_addr), W'(e_wa));
    check("reg_q", reg_q, model_flat());
    if (rs) begin
      check("rst_rx_ack", W'(rx_ack), W'(1'b0));
      check("rst_tx_data", W'(tx_data), W'(8'h00));
    end
    @(negedge clk);
    reset = 0; txn_start = 0; txn_rw = 0; txn_stop = 0;
    rx_valid = 0; rx_data = 8'h00; tx_req = 0;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    step(0, 0, 0, 1, b, 0, 0);
  endtask

  logic [W-1:0] snap;
  int unsigned  r;

  initial begin
    reset = 1; txn_start = 0; txn_rw = 0; txn_stop = 0;
    rx_valid = 0; rx_data = 8'h00; tx_req = 0;
    m_ptr = 0; m_mode = M_IDLE;
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
    @(negedge clk);
    step(0, 0, 0, 0, 8'h00, 0, 1);
    step(0, 0, 0, 0, 8'h00, 0, 1);
    check("reset_regs", reg_q, '0);

    // Pointer then two data bytes.
    step(1, 0, 0, 0, 8'h00, 0, 0);
    wr_byte(8'h03); wr_byte(8'hA5); wr_byte(8'h5A);
    step(0, 0, 1, 0, 8'h00, 0, 0);
    check("t1_reg3", W'(reg_q[8*3 +: 8]), W'(8'hA5));
    check("t1_reg4", W'(reg_q[8*4 +: 8]), W'(8'h5A));

    // Set pointer, repeated start for read, three bytes out.
    step(1, 0, 0, 0, 8'h00, 0, 0);
    wr_byte(8'h02);
    step(1, 1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'h00, 1, 0);
    step(0, 0, 1, 0, 8'h00, 0, 0);

    // Pointer wrap from the last register.
    step(1, 0, 0, 0, 8'h00, 0, 0);
    wr_byte(8'h0F); wr_byte(8'h11); wr_byte(8'h22);
    step(0, 0, 1, 0, 8'h00, 0, 0);
    check("t3_reg15", W'(reg_q[8*15 +: 8]), W'(8'h11));
    check("t3_reg0", W'(reg_q[8*0 +: 8]), W'(8'h22));

    // Out-of-range pointer: everything NACKed, nothing written.
    snap = model_flat();
    step(1, 0, 0, 0, 8'h00, 0, 0);
    wr_byte(8'h20); wr_byte(8'h77);
    step(0, 0, 1, 0, 8'h00, 0, 0);
    check("t4_unchanged", reg_q, snap);

    // Write and stop in the same cycle; start and byte in the same cycle.
    step(1, 0, 0, 0, 8'h00, 0, 0);
    wr_byte(8'h07);
    step(0, 0, 1, 1, 8'h9C, 0, 0);
    check("stop_same_cycle_reg7", W'(reg_q[8*7 +: 8]), W'(8'h9C));
    step(1, 0, 0, 1, 8'h05, 0, 0);
    wr_byte(8'h01); wr_byte(8'h3E);
    step(0, 0, 1, 0, 8'h00, 0, 0);
    check("start_wins_reg1", W'(reg_q[8*1 +: 8]), W'(8'h3E));

`ifdef I2C_REG_BANK_WPROT_EN
    step(1, 0, 0, 0, 8'h00, 0, 0);
    wr_byte(8'h0F); wr_byte(8'h01);
    step(0, 0, 1, 0, 8'h00, 0, 0);
    step(1, 0, 0, 0, 8'h00, 0, 0);
    wr_byte(8'h01); wr_byte(8'hCC);
    step(0, 0, 1, 0, 8'h00, 0, 0);
    check("wprot_blocked", W'(reg_q[8*1 +: 8]), W'(8'h3E));
    step(1, 0, 0, 0, 8'h00, 0, 0);
    wr_byte(8'h0F); wr_byte(8'h00);
    step(0, 0, 1, 0, 8'h00, 0, 0);
    step(1, 0, 0, 0, 8'h00, 0, 0);
    wr_byte(8'h01); wr_byte(8'hCC);
    step(0, 0, 1, 0, 8'h00, 0, 0);
    check("wprot_released", W'(reg_q[8*1 +: 8]), W'(8'hCC));
`endif

    // Reset in the middle of a write burst.
    step(1, 0, 0, 0, 8'h00, 0, 0);
    wr_byte(8'h03); wr_byte(8'h44);
    step(0, 0, 0, 0, 8'h00, 0, 1);
    check("t6_regs_cleared", reg_q, '0);
    wr_byte(8'h55);
    step(0, 0, 0, 0, 8'h00, 1, 0);

    // Random bus activity; pointer bytes biased toward the valid range.
    for (int c = 0; c < 3000; c++) begin
      logic st, rw, sp, rv, tr, rs;
      logic [7:0] rd;
      r  = $urandom_range(0, 99);
      st = (r < 10);
      rw = 1'($urandom_range(0, 1));
      sp = ($urandom_range(0, 99) < 8);
      rv = ($urandom_range(0, 99) < 45);
      tr = ($urandom_range(0, 99) < 30);
      rs = ($urandom_range(0, 999) < 5);
      rd = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, NREG - 1)) : 8'($urandom_range(0, 255));
      step(st, rw, sp, rv, rd, tr, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
